// File: rtl/spi_slave_burst.sv
// SPI mode-0 slave with byte FIFOs in both directions and a five-register CPU window.
// SPI pins are resynchronised into clk_i; every SPI event comes from those synchronised copies.
module spi_slave_burst #(
    parameter int unsigned BaseAddress   = 0,
    parameter int unsigned FifoDepthLog2 = 4,
    parameter int unsigned address_width = 16,
    parameter int unsigned data_width    = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic [address_width-1:0] address_i,
    input  logic [data_width-1:0]    data_i,
    output logic [data_width-1:0]    data_o,
    input  logic                     rd_wr_i,
    input  logic                     spi_clk_i,
    input  logic                     spi_mosi_i,
    input  logic                     spi_sync_ni,
    output logic                     spi_miso_o,
    output logic                     spi_miso_oe_o
);
    localparam int unsigned Depth = 1 << FifoDepthLog2;
    localparam int unsigned Aw    = FifoDepthLog2;
    localparam int unsigned Cw    = FifoDepthLog2 + 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    logic         r_sclk_q1, r_sclk_q2, r_sclk_q3;
    logic         r_mosi_q1, r_mosi_q2;
    logic         r_sync_q1, r_sync_q2, r_sync_q3;
    logic [1:0]   r_sync_vld;
    logic         r_sync_armed;
    state_t       r_state;
    logic [2:0]   r_bit_cnt;
    logic [7:0]   r_rx_sr, r_tx_sr;
    logic         r_byte_done, r_got_byte;
    logic [7:0]   r_frame_cnt;
    logic         r_rx_ovf, r_tx_unr;
    logic [7:0]   r_rx_mem [Depth];
    logic [7:0]   r_tx_mem [Depth];
    logic [Aw-1:0] r_rx_wr, r_rx_rd, r_tx_wr, r_tx_rd;
    logic [Cw-1:0] r_rx_cnt, r_tx_cnt;

    logic w_sclk_rise, w_sclk_fall, w_sync_fall, w_sync_rise;
    logic w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic w_rx_push, w_rx_push_ok, w_rx_pop, w_tx_push_ok, w_tx_pop, w_tx_pop_ok;
    logic w_sel_wb, w_sel_rb, w_sel_st, w_sel_ct, w_sel_fc;
    logic w_ctrl_wr, w_flush, w_frame_active;
    logic [7:0] w_rx_byte, w_tx_head, w_rd_data;

    // Synchronisers; sync only arms once a genuine high level has crossed the chain after reset
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_sclk_q1 <= 1'b0; r_sclk_q2 <= 1'b0; r_sclk_q3 <= 1'b0;
            r_mosi_q1 <= 1'b0; r_mosi_q2 <= 1'b0;
            r_sync_q1 <= 1'b1; r_sync_q2 <= 1'b1; r_sync_q3 <= 1'b1;
            r_sync_vld   <= 2'b00;
            r_sync_armed <= 1'b0;
        end else begin
            r_sclk_q1 <= spi_clk_i;   r_sclk_q2 <= r_sclk_q1; r_sclk_q3 <= r_sclk_q2;
            r_mosi_q1 <= spi_mosi_i;  r_mosi_q2 <= r_mosi_q1;
            r_sync_q1 <= spi_sync_ni; r_sync_q2 <= r_sync_q1; r_sync_q3 <= r_sync_q2;
            r_sync_vld   <= {r_sync_vld[0], 1'b1};
            r_sync_armed <= r_sync_armed | (r_sync_vld[1] & r_sync_q2);
        end
    end

    assign w_sclk_rise    = r_sclk_q2 & ~r_sclk_q3;
    assign w_sclk_fall    = ~r_sclk_q2 & r_sclk_q3;
    assign w_sync_fall    = r_sync_armed & r_sync_q3 & ~r_sync_q2;
    assign w_sync_rise    = r_sync_q2 & ~r_sync_q3;
    assign w_frame_active = (r_state == SHIFT);

    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == Cw'(Depth));
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == Cw'(Depth));
    assign w_tx_head  = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd];
    assign w_rx_byte  = {r_rx_sr[6:0], r_mosi_q2};

    assign w_sel_wb = (address_i == address_width'(BaseAddress));
    assign w_sel_rb = (address_i == address_width'(BaseAddress + 32'd1));
    assign w_sel_st = (address_i == address_width'(BaseAddress + 32'd2));
    assign w_sel_ct = (address_i == address_width'(BaseAddress + 32'd3));
    assign w_sel_fc = (address_i == address_width'(BaseAddress + 32'd4));

    assign w_ctrl_wr    = w_sel_ct & rd_wr_i;
    assign w_flush      = w_ctrl_wr & data_i[2] & ~w_frame_active;
    assign w_tx_push_ok = w_sel_wb & rd_wr_i & ~w_tx_full;
    assign w_rx_pop     = w_sel_rb & ~rd_wr_i & ~w_rx_empty;
    assign w_rx_push    = w_frame_active & ~w_sync_rise & w_sclk_rise & (r_bit_cnt == 3'd7);
    assign w_rx_push_ok = w_rx_push & ~w_rx_full;
    assign w_tx_pop     = (~w_frame_active & w_sync_fall)
                        | (w_frame_active & ~w_sync_rise & w_sclk_fall & r_byte_done);
    assign w_tx_pop_ok  = w_tx_pop & ~w_tx_empty;

    always_ff @(posedge clk_i) begin
        if (w_rx_push_ok) r_rx_mem[r_rx_wr] <= w_rx_byte;
        if (w_tx_push_ok) r_tx_mem[r_tx_wr] <= data_i[7:0];
    end

    // FIFO pointers and occupancy; simultaneous push and pop both apply
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_rx_wr <= '0; r_rx_rd <= '0; r_rx_cnt <= '0;
            r_tx_wr <= '0; r_tx_rd <= '0; r_tx_cnt <= '0;
        end else if (w_flush) begin
            r_rx_wr <= '0; r_rx_rd <= '0; r_rx_cnt <= '0;
            r_tx_wr <= '0; r_tx_rd <= '0; r_tx_cnt <= '0;
        end else begin
            if (w_rx_push_ok) r_rx_wr <= r_rx_wr + Aw'(1);
            if (w_rx_pop)     r_rx_rd <= r_rx_rd + Aw'(1);
            r_rx_cnt <= r_rx_cnt + Cw'(w_rx_push_ok) - Cw'(w_rx_pop);
            if (w_tx_push_ok) r_tx_wr <= r_tx_wr + Aw'(1);
            if (w_tx_pop_ok)  r_tx_rd <= r_tx_rd + Aw'(1);
            r_tx_cnt <= r_tx_cnt + Cw'(w_tx_push_ok) - Cw'(w_tx_pop_ok);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_rx_ovf <= 1'b0;
            r_tx_unr <= 1'b0;
        end else begin
            r_rx_ovf <= (r_rx_ovf & ~(w_ctrl_wr & data_i[0])) | (w_rx_push & w_rx_full);
            r_tx_unr <= (r_tx_unr & ~(w_ctrl_wr & data_i[1])) | (w_tx_pop & w_tx_empty);
        end
    end

    // Frame engine: sample on SCLK rise, shift MISO on SCLK fall
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state       <= IDLE;
            r_bit_cnt     <= 3'd0;
            r_rx_sr       <= 8'h00;
            r_tx_sr       <= 8'h00;
            r_byte_done   <= 1'b0;
            r_got_byte    <= 1'b0;
            r_frame_cnt   <= 8'h00;
            spi_miso_o    <= 1'b0;
            spi_miso_oe_o <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sync_fall) begin
                        r_state       <= SHIFT;
                        r_tx_sr       <= w_tx_head;
                        spi_miso_o    <= w_tx_head[7];
                        spi_miso_oe_o <= 1'b1;
                        r_bit_cnt     <= 3'd0;
                        r_byte_done   <= 1'b0;
                        r_got_byte    <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (w_sync_rise) begin
                        r_state       <= IDLE;
                        spi_miso_o    <= 1'b0;
                        spi_miso_oe_o <= 1'b0;
                        if (r_got_byte) r_frame_cnt <= r_frame_cnt + 8'd1;
                    end else if (w_sclk_rise) begin
                        r_rx_sr   <= w_rx_byte;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_byte_done <= 1'b1;
                            r_got_byte  <= 1'b1;
                        end
                    end else if (w_sclk_fall) begin
                        if (r_byte_done) begin
                            r_tx_sr     <= w_tx_head;
                            spi_miso_o  <= w_tx_head[7];
                            r_byte_done <= 1'b0;
                        end else begin
                            r_tx_sr    <= {r_tx_sr[6:0], 1'b0};
                            spi_miso_o <= r_tx_sr[6];
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_rd_data = 8'h00;
        if (!rd_wr_i) begin
            if (w_sel_rb)      w_rd_data = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd];
            else if (w_sel_st) w_rd_data = {3'b000, r_tx_unr, r_rx_ovf, w_frame_active, w_tx_full, w_rx_empty};
            else if (w_sel_fc) w_rd_data = r_frame_cnt;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) data_o <= '0;
        else           data_o <= data_width'(w_rd_data);
    end
endmodule

// File: tb/tb_spi_slave_burst.sv
// Directed bench for spi_slave_burst: acts as CPU and SPI mode-0 master at clk/10.
module tb_spi_slave_burst;
    localparam logic [15:0] A_WB = 16'h0000, A_RB = 16'h0001, A_ST = 16'h0002,
                            A_CT = 16'h0003, A_FC = 16'h0004, A_PARK = 16'h00FF;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [15:0] address_i;
    logic [7:0]  data_i;
    logic [7:0]  data_o;
    logic        rd_wr_i;
    logic        spi_clk_i, spi_mosi_i, spi_sync_ni;
    logic        spi_miso_o, spi_miso_oe_o;

    int n_checks = 0;
    int n_fail   = 0;

    spi_slave_burst dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .address_i(address_i), .data_i(data_i),
        .data_o(data_o), .rd_wr_i(rd_wr_i), .spi_clk_i(spi_clk_i), .spi_mosi_i(spi_mosi_i),
        .spi_sync_ni(spi_sync_ni), .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk_i);
        address_i = a; data_i = d; rd_wr_i = 1'b1;
        @(negedge clk_i);
        address_i = A_PARK; data_i = 8'h00; rd_wr_i = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk_i);
        address_i = a; rd_wr_i = 1'b0;
        @(negedge clk_i);
        d = data_o;
        address_i = A_PARK;
    endtask

    task automatic spi_start();
        @(negedge clk_i);
        spi_sync_ni = 1'b0;
        repeat (6) @(negedge clk_i);
    endtask

    task automatic spi_end();
        repeat (5) @(negedge clk_i);
        spi_sync_ni = 1'b1;
        repeat (6) @(negedge clk_i);
    endtask

    // n bits MSB-first; optionally issue one Read_Byte pop aligned with the last-bit RX push
    task automatic spi_bits(input logic [7:0] tx, input int n, input bit pop_last,
                            output logic [7:0] rx, output logic [7:0] popped);
        rx = 8'h00; popped = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi_i = tx[7-i];
            repeat (5) @(negedge clk_i);
            spi_clk_i = 1'b1;
            rx = {rx[6:0], spi_miso_o};
            if (pop_last && i == n - 1) begin
                repeat (2) @(negedge clk_i);
                address_i = A_RB; rd_wr_i = 1'b0;
                @(negedge clk_i);
                popped = data_o;
                address_i = A_PARK;
                repeat (2) @(negedge clk_i);
            end else begin
                repeat (5) @(negedge clk_i);
            end
            spi_clk_i = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rd, rx, pp;
        reset_ni = 1'b0; address_i = A_PARK; data_i = 8'h00; rd_wr_i = 1'b0;
        spi_clk_i = 1'b0; spi_mosi_i = 1'b0; spi_sync_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        check_eq("rst_data_o", data_o, 8'h00);
        check_eq("rst_miso", {7'b0, spi_miso_o}, 8'h00);
        check_eq("rst_oe", {7'b0, spi_miso_oe_o}, 8'h00);
        reset_ni = 1'b1;
        repeat (5) @(negedge clk_i);
        cpu_read(A_ST, rd); check_eq("status_reset", rd, 8'h01);

        // Single byte exchange
        cpu_write(A_WB, 8'hA5);
        spi_start();
        check_eq("t1_oe_active", {7'b0, spi_miso_oe_o}, 8'h01);
        cpu_read(A_ST, rd); check_eq("t1_status_active", rd, 8'h05);
        spi_bits(8'h3C, 8, 1'b0, rx, pp);
        check_eq("t1_master_rx", rx, 8'hA5);
        spi_end();
        check_eq("t1_oe_idle", {7'b0, spi_miso_oe_o}, 8'h00);
        check_eq("t1_miso_idle", {7'b0, spi_miso_o}, 8'h00);
        cpu_read(A_RB, rd); check_eq("t1_read_byte", rd, 8'h3C);
        cpu_read(A_FC, rd); check_eq("t1_frame_cnt", rd, 8'h01);
        cpu_write(A_CT, 8'h03);
        cpu_read(A_ST, rd); check_eq("t1_status_clr", rd, 8'h01);

        // Underrun with empty TX FIFO
        spi_start();
        spi_bits(8'h11, 8, 1'b0, rx, pp); check_eq("t2_miso_b0", rx, 8'h00);
        spi_bits(8'h22, 8, 1'b0, rx, pp); check_eq("t2_miso_b1", rx, 8'h00);
        spi_end();
        cpu_read(A_ST, rd); check_eq("t2_status_unr", rd, 8'h10);
        cpu_write(A_CT, 8'h02);
        cpu_read(A_ST, rd); check_eq("t2_status_unr_clr", rd, 8'h00);
        cpu_read(A_RB, rd); check_eq("t2_rb0", rd, 8'h11);
        cpu_read(A_RB, rd); check_eq("t2_rb1", rd, 8'h22);

        // RX overflow: 17 bytes into a 16-entry FIFO
        spi_start();
        for (int i = 0; i < 17; i++) spi_bits(8'(8'h40 + i), 8, 1'b0, rx, pp);
        spi_end();
        cpu_read(A_ST, rd); check_eq("t3_status_ovf", rd, 8'h18);
        for (int i = 0; i < 16; i++) begin
            cpu_read(A_RB, rd); check_eq($sformatf("t3_rb%0d", i), rd, 8'(8'h40 + i));
        end
        cpu_read(A_RB, rd); check_eq("t3_rb_empty", rd, 8'h00);
        cpu_read(A_ST, rd); check_eq("t3_status_empty", rd, 8'h19);
        cpu_write(A_CT, 8'h03);
        cpu_read(A_FC, rd); check_eq("t3_frame_cnt", rd, 8'h03);

        // TX full and flush
        for (int i = 0; i < 16; i++) cpu_write(A_WB, 8'(8'h60 + i));
        cpu_read(A_ST, rd); check_eq("tx_full", rd, 8'h03);
        cpu_write(A_CT, 8'h04);
        cpu_read(A_ST, rd); check_eq("tx_flushed", rd, 8'h01);

        // Partial second byte discarded
        cpu_write(A_WB, 8'hC3);
        spi_start();
        spi_bits(8'h77, 8, 1'b0, rx, pp); check_eq("t4_master_rx", rx, 8'hC3);
        spi_bits(8'h88, 5, 1'b0, rx, pp);
        spi_end();
        check_eq("t4_oe_idle", {7'b0, spi_miso_oe_o}, 8'h00);
        cpu_read(A_FC, rd); check_eq("t4_frame_cnt", rd, 8'h04);
        cpu_read(A_RB, rd); check_eq("t4_rb0", rd, 8'h77);
        cpu_read(A_RB, rd); check_eq("t4_rb_empty", rd, 8'h00);
        cpu_read(A_ST, rd); check_eq("t4_status", rd, 8'h11);
        cpu_write(A_CT, 8'h03);

        // Same-cycle CPU pop and SPI push at occupancy 1
        spi_start(); spi_bits(8'h11, 8, 1'b0, rx, pp); spi_end();
        spi_start(); spi_bits(8'h22, 8, 1'b1, rx, pp); spi_end();
        check_eq("t5_popped", pp, 8'h11);
        cpu_read(A_ST, rd); check_eq("t5_status_occ1", rd, 8'h10);
        cpu_read(A_RB, rd); check_eq("t5_rb", rd, 8'h22);
        cpu_read(A_ST, rd); check_eq("t5_status_empty", rd, 8'h11);
        cpu_write(A_CT, 8'h03);

        // Reset mid-byte, then no transfer until a fresh sync fall
        cpu_write(A_WB, 8'hFF);
        cpu_write(A_WB, 8'hEE);
        @(negedge clk_i); address_i = A_FC; rd_wr_i = 1'b0;
        spi_start();
        spi_bits(8'h0F, 3, 1'b0, rx, pp);
        check_eq("t6_pre_miso", {7'b0, spi_miso_o}, 8'h01);
        check_eq("t6_pre_data_o", data_o, 8'h06);
        #2 reset_ni = 1'b0;
        #1;
        check_eq("t6_rst_data_o", data_o, 8'h00);
        check_eq("t6_rst_miso", {7'b0, spi_miso_o}, 8'h00);
        check_eq("t6_rst_oe", {7'b0, spi_miso_oe_o}, 8'h00);
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        address_i = A_PARK;
        repeat (12) @(negedge clk_i);
        spi_bits(8'hAA, 8, 1'b0, rx, pp);
        check_eq("t6_no_start_oe", {7'b0, spi_miso_oe_o}, 8'h00);
        cpu_read(A_ST, rd); check_eq("t6_status", rd, 8'h01);
        cpu_read(A_FC, rd); check_eq("t6_frame_cnt", rd, 8'h00);
        spi_sync_ni = 1'b1;
        repeat (6) @(negedge clk_i);
        spi_start();
        spi_bits(8'h5A, 8, 1'b0, rx, pp); check_eq("t6_tx_flushed", rx, 8'h00);
        spi_end();
        cpu_read(A_RB, rd); check_eq("t6_rb", rd, 8'h5A);
        cpu_read(A_FC, rd); check_eq("t6_frame_cnt2", rd, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
